// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Central hold / bubble / flush sequencer for the five-stage pipeline.
// Collects stall and flush requests from ID (load_use), EX (ex_busy),
// MEM (mem_wait) and debug (halt_req). It drives the hold enables and the
// bubble/clear controls of the PC and pipeline registers. A flush that
// arrives while MEM is blocked is remembered and replayed once the
// blocking condition drops. The block also runs a memory-wait watchdog
// and a saturating stall-cycle counter.
//
// Ports
//   clk, rst (async, active-low)
//   halt_req, mem_wait, ex_busy, load_use, flush_req, timeout_clr : requests
//   hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb      : hold enables
//   clear_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb        : NOP/zero loads
//   flush_pending : deferred flush outstanding
//   mem_timeout   : sticky watchdog flag
//   stall_count   : saturating count of cycles with hold_pc = 1
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic             mem_wait,
  input  logic             ex_busy,
  input  logic             load_use,
  input  logic             flush_req,
  input  logic             timeout_clr,
  output logic             hold_pc,
  output logic             hold_if_id,
  output logic             hold_id_ex,
  output logic             hold_ex_mem,
  output logic             hold_mem_wb,
  output logic             clear_if_id,
  output logic             bubble_id_ex,
  output logic             bubble_ex_mem,
  output logic             bubble_mem_wb,
  output logic             flush_pending,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, FPEND} state_t;

  localparam logic [7:0] TO_VAL = 8'(MEM_TIMEOUT);

  state_t           state_reg, state_next;
  logic [7:0]       wcnt_reg, wcnt_next;
  logic             mem_timeout_reg, mem_timeout_next;
  logic [CNT_W-1:0] stall_count_reg, stall_count_next;

  logic blk;
  logic do_flush;
  logic to_set;

  assign blk      = halt_req | mem_wait;
  // A pending flush replays on the first unblocked cycle even without a new request.
  assign do_flush = !blk && (flush_req || (state_reg == FPEND));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= RUN;
      wcnt_reg        <= '0;
      mem_timeout_reg <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      wcnt_reg        <= wcnt_next;
      mem_timeout_reg <= mem_timeout_next;
      stall_count_reg <= stall_count_next;
    end
  end

  // Next state and the prioritised hold/bubble decode
  always_comb begin
    state_next    = state_reg;
    hold_pc       = 1'b0;
    hold_if_id    = 1'b0;
    hold_id_ex    = 1'b0;
    hold_ex_mem   = 1'b0;
    hold_mem_wb   = 1'b0;
    clear_if_id   = 1'b0;
    bubble_id_ex  = 1'b0;
    bubble_ex_mem = 1'b0;
    bubble_mem_wb = 1'b0;

    case (state_reg)
      RUN:     if (flush_req && blk) state_next = FPEND;
      FPEND:   if (do_flush)         state_next = RUN;
      default: state_next = RUN;
    endcase

    if (halt_req) begin
      hold_pc     = 1'b1;
      hold_if_id  = 1'b1;
      hold_id_ex  = 1'b1;
      hold_ex_mem = 1'b1;
      hold_mem_wb = 1'b1;
    end else if (mem_wait) begin
      // MEM keeps its instruction; WB receives a NOP meanwhile.
      hold_pc       = 1'b1;
      hold_if_id    = 1'b1;
      hold_id_ex    = 1'b1;
      hold_ex_mem   = 1'b1;
      bubble_mem_wb = 1'b1;
    end else if (do_flush) begin
      // Killed instructions must not keep stalling the pipe.
      clear_if_id   = 1'b1;
      bubble_id_ex  = 1'b1;
      bubble_ex_mem = 1'b1;
    end else if (ex_busy) begin
      hold_pc       = 1'b1;
      hold_if_id    = 1'b1;
      hold_id_ex    = 1'b1;
      bubble_ex_mem = 1'b1;
    end else if (load_use) begin
      hold_pc      = 1'b1;
      hold_if_id   = 1'b1;
      bubble_id_ex = 1'b1;
    end
  end

  // Watchdog: counts consecutive unhalted mem_wait cycles, frozen by halt.
  always_comb begin
    wcnt_next = wcnt_reg;
    if (!mem_wait)
      wcnt_next = '0;
    else if (!halt_req && (wcnt_reg != TO_VAL))
      wcnt_next = wcnt_reg + 8'd1;
  end

  // Flag only on the edge where the count arrives at the limit.
  assign to_set = (wcnt_reg != TO_VAL) && (wcnt_next == TO_VAL);

  always_comb begin
    mem_timeout_next = mem_timeout_reg;
    if (to_set)
      mem_timeout_next = 1'b1;
    else if (timeout_clr)
      mem_timeout_next = 1'b0;
  end

  // Saturating stall counter
  always_comb begin
    stall_count_next = stall_count_reg;
    if (hold_pc && (stall_count_reg != {CNT_W{1'b1}}))
      stall_count_next = stall_count_reg + CNT_W'(1);
  end

  assign flush_pending = (state_reg == FPEND);
  assign mem_timeout   = mem_timeout_reg;
  assign stall_count   = stall_count_reg;

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central hold/bubble/flush sequencer for the five-stage pipeline. It collects stall and flush requests from the ID, EX and MEM stages and from the debug halt line, and drives the `is_hold` enables of the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB registers. It also drives the bubble (load-NOP) and clear controls of those registers. A flush that arrives while MEM is blocked is deferred and replayed later. The block also runs a memory-wait watchdog and a saturating stall-cycle counter.

## Interface

Clock is `clk`. Reset is `rst`, asynchronous and active-low.

**Parameters**
- `MEM_TIMEOUT`, default 16: consecutive `mem_wait` cycles that raise `mem_timeout`. Range 1..255.
- `CNT_W`, default 32: width of `stall_count`.

**Ports**
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: asynchronous reset, active-low.
- `halt_req`, in, 1: debug halt; freezes every stage.
- `mem_wait`, in, 1: MEM-stage data memory not ready.
- `ex_busy`, in, 1: EX multi-cycle mult/div in progress.
- `load_use`, in, 1: ID load-use hazard.
- `flush_req`, in, 1: redirect/exception; kill IF, ID and EX contents.
- `timeout_clr`, in, 1: synchronous clear of `mem_timeout`.
- `hold_pc`, out, 1: PC hold enable.
- `hold_if_id`, out, 1: IF_ID hold enable.
- `hold_id_ex`, out, 1: ID_EX hold enable.
- `hold_ex_mem`, out, 1: EX_MEM hold enable.
- `hold_mem_wb`, out, 1: MEM_WB hold enable.
- `clear_if_id`, out, 1: IF_ID loads zero on the next edge.
- `bubble_id_ex`, out, 1: ID_EX loads a NOP on the next edge.
- `bubble_ex_mem`, out, 1: EX_MEM loads a NOP on the next edge.
- `bubble_mem_wb`, out, 1: MEM_WB loads a NOP on the next edge.
- `flush_pending`, out, 1: a deferred flush is outstanding.
- `mem_timeout`, out, 1: sticky watchdog flag.
- `stall_count`, out, CNT_W: cycles with `hold_pc`=1, saturating.

## Operation

**State machine**
- Two states: RUN and FPEND. `flush_pending` = (state == FPEND).
- Define `blk` = `halt_req` | `mem_wait`.
- `do_flush` = !`blk` & (`flush_req` | FPEND).

**Output priority** (combinational from the inputs and state, evaluated top-down)
1. `halt_req`: all five holds = 1; all bubbles and clear = 0.
2. `mem_wait`: holds for PC, IF_ID, ID_EX, EX_MEM = 1; `bubble_mem_wb` = 1; `hold_mem_wb` = 0.
3. `do_flush`: all holds = 0; `clear_if_id`, `bubble_id_ex`, `bubble_ex_mem` = 1. The flush overrides `ex_busy` and `load_use`, because the instructions requesting those stalls are being killed.
4. `ex_busy`: holds for PC, IF_ID, ID_EX = 1; `bubble_ex_mem` = 1.
5. `load_use`: holds for PC, IF_ID = 1; `bubble_id_ex` = 1.
6. Otherwise: all outputs 0.

**State transitions**
- RUN → FPEND when `flush_req` & `blk`.
- FPEND → RUN on an edge where `do_flush` = 1.
- A `flush_req` pulse that arrives while FPEND is already set merges into the single pending flush.
- In FPEND, `flush_req` does not need to stay high; the flush is replayed on the first cycle with `blk` = 0.

**Watchdog**
- 8-bit `wcnt` increments on each edge with `mem_wait` & !`halt_req`.
- `wcnt` holds its value while `halt_req`=1.
- `wcnt` clears to 0 when `mem_wait`=0.
- `wcnt` stops counting at `MEM_TIMEOUT`.
- `mem_timeout` sets on the edge where `wcnt` reaches `MEM_TIMEOUT`, and stays set until `timeout_clr` or reset.
- If set and clear conditions occur on the same edge, set wins.
- `mem_timeout` only reports; it does not change the hold outputs.

**Stall counter**
- `stall_count` increments on each edge with `hold_pc`=1.
- It saturates at all-ones.

## Timing

- **Reset** (`rst`=0, asynchronous): state = RUN, `wcnt` = 0, `mem_timeout` = 0, `stall_count` = 0.
- **Outputs during reset** are decoded from the inputs with state = RUN. With all inputs 0, every output is 0.
- **Latency**: requests reach the hold/bubble outputs in the same cycle with zero latency. The target registers act on the next rising edge.
- **Deferred flush**: applied in the first cycle after `blk` falls.
- **Timeout assertion**: `mem_timeout` is high after the `MEM_TIMEOUT`-th consecutive `mem_wait` edge.
- **Reset mid-operation**: a pending flush is discarded, and the watchdog and `stall_count` are zeroed.
- **Release timing**: when `mem_wait` and `ex_busy` release on the same cycle, the `ex_busy` row applies immediately.

## Test plan

- **Load-use**: pulse `load_use` for 1 cycle → `hold_pc`, `hold_if_id`, `bubble_id_ex` = 1 for exactly that cycle; `stall_count` goes 0→1.
- **Deferred flush**: `mem_wait` high for 3 cycles with a 1-cycle `flush_req` in cycle 1 → `flush_pending` = 1 from cycle 2. In cycle 3 (`mem_wait`=0), `clear_if_id`, `bubble_id_ex`, `bubble_ex_mem` = 1 and all holds = 0. `flush_pending` = 0 in cycle 4.
- **Flush beats stalls**: `flush_req` together with `ex_busy` and `load_use` → flush outputs only; `hold_pc` = 0; `stall_count` unchanged.
- **Watchdog**: `mem_wait` held for 16 cycles (`MEM_TIMEOUT`=16) → `mem_timeout` = 1 after the 16th edge, and it stays 1 after `mem_wait` drops. Pulsing `timeout_clr` → 0. Holding `mem_wait` for only 15 cycles never sets it.
- **Halt**: `halt_req` during `mem_wait` → all five holds = 1, `bubble_mem_wb` = 0, `wcnt` frozen. Releasing `halt_req` resumes the count from its frozen value.
- **Saturation and reset**: with `CNT_W`=4, hold `ex_busy` for 20 cycles → `stall_count` = 15. An asynchronous `rst` low mid-cycle with FPEND set → `stall_count` = 0 and `flush_pending` = 0 immediately.
